defl_arb_stage: RTL and testbench

- Registered 2x2 deflection-arbitration stage for the MinBD router. Sits between the input-port latches and the crossbar.
- Each cycle it ranks the two incoming 11-bit flits (golden > silver > plain) and steers the winner to its productive port. The loser takes the remaining port.
- It owns the golden-epoch schedule and an LFSR tie-breaker, and it counts deflections.

---
 rtl/defl_arb_stage.sv | 112 +++++++++++
 tb/tb_defl_arb_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/defl_arb_stage.sv
// Registered 2x2 deflection arbitration stage for the MinBD router.
// Ranks two flits, steers the winner productively, tracks golden epochs.
module defl_arb_stage #(
  parameter int         EPOCH_LEN = 64,
  parameter int         NUM_NODES = 8,
  parameter logic [2:0] PROD_CODE = 3'b010,
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld1,
  input  logic [10:0]      in_flit1,
  input  logic             in_vld2,
  input  logic [10:0]      in_flit2,
  input  logic             clr_cnt,
  output logic             out_vld1,
  output logic [10:0]      out_flit1,
  output logic             out_vld2,
  output logic [10:0]      out_flit2,
  output logic [2:0]       golden_id,
  output logic [CNT_W-1:0] deflect_cnt
);

  localparam int EW = $clog2(EPOCH_LEN);

  logic [EW-1:0] epoch;
  logic [7:0]    lfsr;
  logic          lfsr_fb;

  logic          g1, g2;
  logic [10:0]   f1, f2;
  logic [1:0]    r1, r2;
  logic          w2;
  logic          wv, lv;
  logic [10:0]   wf, lf;
  logic          wprod;
  logic          nv1, nv2;
  logic [10:0]   nf1, nf2;
  logic          defl;

  // Golden marking, ranking, winner pick and port steering.
  always_comb begin
    g1 = in_flit1[10] | (in_flit1[5:3] == golden_id);
    g2 = in_flit2[10] | (in_flit2[5:3] == golden_id);
    f1 = in_vld1 ? {g1, in_flit1[9:0]} : 11'd0;
    f2 = in_vld2 ? {g2, in_flit2[9:0]} : 11'd0;
    r1 = !in_vld1 ? 2'd0 : g1 ? 2'd3 :
         in_flit1[9] ? 2'd2 : 2'd1;
    r2 = !in_vld2 ? 2'd0 : g2 ? 2'd3 :
         in_flit2[9] ? 2'd2 : 2'd1;
    w2 = (r2 > r1) |
         ((r2 == r1) & in_vld1 & in_vld2 & lfsr[0]);
    wv = w2 ? in_vld2 : in_vld1;
    wf = w2 ? f2 : f1;
    lv = w2 ? in_vld1 : in_vld2;
    lf = w2 ? f1 : f2;
    wprod = wv & (wf[8:6] == PROD_CODE);
    nv1 = wprod ? wv : lv;
    nf1 = wprod ? wf : lf;
    nv2 = wprod ? lv : wv;
    nf2 = wprod ? lf : wf;
    defl = nv2 & (nf2[8:6] == PROD_CODE);
  end

  // Output register: one cycle of latency, no backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld1  <= 1'b0;
      out_flit1 <= 11'd0;
      out_vld2  <= 1'b0;
      out_flit2 <= 11'd0;
    end else begin
      out_vld1  <= nv1;
      out_flit1 <= nf1;
      out_vld2  <= nv2;
      out_flit2 <= nf2;
    end
  end

  // Epoch counter; golden source rotates on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epoch     <= '0;
      golden_id <= 3'd0;
    end else if (epoch == EW'(EPOCH_LEN - 1)) begin
      epoch     <= '0;
      golden_id <= (golden_id + 3'd1) & 3'(NUM_NODES - 1);
    end else begin
      epoch <= epoch + EW'(1);
    end
  end

  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  // Tie-break LFSR, free running every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[6:0], lfsr_fb};
  end

  // Saturating deflection counter; clear wins over a deflection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      deflect_cnt <= '0;
    else if (clr_cnt)
      deflect_cnt <= '0;
    else if (defl && !(&deflect_cnt))
      deflect_cnt <= deflect_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_defl_arb_stage.sv
// Directed bench for defl_arb_stage.
// Second instance with a 2-bit counter exercises saturation.
module tb_defl_arb_stage;

  logic        clk;
  logic        rst_n;
  logic        in_vld1, in_vld2, clr_cnt;
  logic [10:0] in_flit1, in_flit2;
  logic        out_vld1, out_vld2;
  logic [10:0] out_flit1, out_flit2;
  logic [2:0]  golden_id;
  logic [15:0] deflect_cnt;

  logic        s_vld1, s_vld2;
  logic [10:0] s_flit1, s_flit2;
  logic [2:0]  s_gid;
  logic [1:0]  s_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  lfsr_m;
  logic [10:0] e1, e2, base1, base2;
  logic        g1, g2, w2;
  int          gid;

  defl_arb_stage #(
    .EPOCH_LEN(4), .NUM_NODES(8), .PROD_CODE(3'b010),
    .LFSR_SEED(8'hA5), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld1(in_vld1), .in_flit1(in_flit1),
    .in_vld2(in_vld2), .in_flit2(in_flit2),
    .clr_cnt(clr_cnt),
    .out_vld1(out_vld1), .out_flit1(out_flit1),
    .out_vld2(out_vld2), .out_flit2(out_flit2),
    .golden_id(golden_id), .deflect_cnt(deflect_cnt)
  );

  defl_arb_stage #(
    .EPOCH_LEN(4), .NUM_NODES(8), .PROD_CODE(3'b010),
    .LFSR_SEED(8'hA5), .CNT_W(2)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_vld1(in_vld1), .in_flit1(in_flit1),
    .in_vld2(in_vld2), .in_flit2(in_flit2),
    .clr_cnt(clr_cnt),
    .out_vld1(s_vld1), .out_flit1(s_flit1),
    .out_vld2(s_vld2), .out_flit2(s_flit2),
    .golden_id(s_gid), .deflect_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v1, input logic [10:0] f1,
                       input logic v2, input logic [10:0] f2,
                       input logic clr);
    in_vld1  = v1;
    in_flit1 = f1;
    in_vld2  = v2;
    in_flit2 = f2;
    clr_cnt  = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag,
                         input logic v1, input logic [10:0] f1,
                         input logic v2, input logic [10:0] f2);
    chk({tag, "_v1"}, 16'(out_vld1), 16'(v1));
    chk({tag, "_f1"}, 16'(out_flit1), 16'(f1));
    chk({tag, "_v2"}, 16'(out_vld2), 16'(v2));
    chk({tag, "_f2"}, 16'(out_flit2), 16'(f2));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 11'd0, 1'b0, 11'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 11'($urandom),
            1'($urandom), 11'($urandom), 1'($urandom));
      tick();
    end
    chk_out("rst", 1'b0, 11'd0, 1'b0, 11'd0);
    chk("rst_gid", 16'(golden_id), 16'd0);
    chk("rst_cnt", deflect_cnt, 16'd0);
    chk("rst_scnt", 16'(s_cnt), 16'd0);

    rst_n = 1'b1;
    drive(1'b1, 11'h298, 1'b1, 11'h0A8, 1'b0);
    tick();
    chk_out("silver", 1'b1, 11'h298, 1'b1, 11'h0A8);
    chk("silver_cnt", deflect_cnt, 16'd1);
    chk("silver_scnt", 16'(s_cnt), 16'd1);

    drive(1'b0, 11'd0, 1'b0, 11'd0, 1'b0);
    repeat (19) tick();
    chk_out("idle", 1'b0, 11'd0, 1'b0, 11'd0);
    chk("idle_gid", 16'(golden_id), 16'd5);
    chk("idle_cnt", deflect_cnt, 16'd1);

    drive(1'b1, 11'h298, 1'b1, 11'h0A8, 1'b0);
    tick();
    chk_out("gold", 1'b1, 11'h4A8, 1'b1, 11'h298);
    chk("gold_cnt", deflect_cnt, 16'd2);
    chk("gold_scnt", 16'(s_cnt), 16'd2);

    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    lfsr_m = 8'hA5;
    base1 = 11'h088;
    base2 = 11'h0B0;
    for (int k = 1; k <= 32; k++) begin
      gid = ((k - 1) / 4) % 8;
      g1 = (gid == 1);
      g2 = (gid == 6);
      e1 = {g1, base1[9:0]};
      e2 = {g2, base2[9:0]};
      w2 = g2 ? 1'b1 : g1 ? 1'b0 : lfsr_m[0];
      lfsr_m = {lfsr_m[6:0],
                lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
      drive(1'b1, base1, 1'b1, base2, 1'b0);
      tick();
      chk($sformatf("tie%0d_f1", k), 16'(out_flit1),
          16'(w2 ? e2 : e1));
      chk($sformatf("tie%0d_f2", k), 16'(out_flit2),
          16'(w2 ? e1 : e2));
      chk($sformatf("tie%0d_cnt", k), deflect_cnt, 16'(k));
      chk($sformatf("tie%0d_scnt", k), 16'(s_cnt),
          16'(k < 3 ? k : 3));
      chk($sformatf("tie%0d_gid", k), 16'(golden_id),
          16'((k / 4) % 8));
    end

    drive(1'b0, 11'h7FF, 1'b1, 11'h04C, 1'b0);
    tick();
    chk_out("single", 1'b0, 11'd0, 1'b1, 11'h04C);
    chk("single_cnt", deflect_cnt, 16'd32);

    drive(1'b1, 11'h298, 1'b1, 11'h0A8, 1'b1);
    tick();
    chk_out("clr", 1'b1, 11'h298, 1'b1, 11'h0A8);
    chk("clr_cnt", deflect_cnt, 16'd0);
    chk("clr_scnt", 16'(s_cnt), 16'd0);

    drive(1'b1, 11'h298, 1'b1, 11'h0A8, 1'b0);
    tick();
    chk("post_clr_cnt", deflect_cnt, 16'd1);

    drive(1'b0, 11'd0, 1'b0, 11'd0, 1'b0);
    repeat (4) tick();
    drive(1'b1, 11'h298, 1'b1, 11'h0A8, 1'b0);
    tick();
    chk_out("pre_arst", 1'b1, 11'h298, 1'b1, 11'h0A8);
    chk("pre_arst_cnt", deflect_cnt, 16'd2);
    chk("pre_arst_gid", 16'(golden_id), 16'd2);

    #2;
    rst_n = 1'b0;
    #1;
    chk_out("arst", 1'b0, 11'd0, 1'b0, 11'd0);
    chk("arst_gid", 16'(golden_id), 16'd0);
    chk("arst_cnt", deflect_cnt, 16'd0);
    chk("arst_scnt", 16'(s_cnt), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
